// File: rtl/prog_logic_fn_if.sv
`default_nettype none
// ============================================================================
// Module      : prog_logic_fn_if
// Description : Evaluation and serial-configuration bundle for prog_logic_fn.
// Revision    : 1.0 - initial release
// ============================================================================
interface prog_logic_fn_if #(
    parameter int N_IN = 4
);
    logic            in_valid;
    logic [N_IN-1:0] in_vec;
    logic            cfg_en;
    logic            cfg_bit;
    logic            cfg_restart;
    logic            f;
    logic            out_valid;
    logic            cfg_busy;
    logic            cfg_done;

    modport master (
        output in_valid, in_vec, cfg_en, cfg_bit, cfg_restart,
        input  f, out_valid, cfg_busy, cfg_done
    );

    modport slave (
        input  in_valid, in_vec, cfg_en, cfg_bit, cfg_restart,
        output f, out_valid, cfg_busy, cfg_done
    );
endinterface
`default_nettype wire

// File: rtl/prog_logic_fn.sv
`default_nettype none
// ============================================================================
// Module      : prog_logic_fn
// Description : Registered N-input truth-table function with a serially
//               reloadable table (shadow load, atomic commit on last bit).
// Revision    : 1.0 - initial release
// ============================================================================
module prog_logic_fn #(
    parameter int                    N_IN        = 4,
    parameter logic [(1<<N_IN)-1:0]  RESET_TABLE = 16'h0054
) (
    input  wire                  clk,
    input  wire                  rst,
    prog_logic_fn_if.slave       bus
);
    localparam int              c_DEPTH = 1 << N_IN;
    localparam logic [N_IN-1:0] c_LAST  = {N_IN{1'b1}};

    logic [c_DEPTH-1:0] r_active;
    logic [c_DEPTH-1:0] r_shadow;
    logic [N_IN-1:0]    r_count;
    logic               r_f;
    logic               r_out_valid;
    logic               r_busy;
    logic               r_done;

    logic [c_DEPTH-1:0] w_merged;
    logic               w_last;

    // Shadow image with the incoming bit already placed, so the final bit
    // can be committed to the active table on the same edge it arrives.
    always_comb begin
        w_merged          = r_shadow;
        w_merged[r_count] = bus.cfg_bit;
    end

    assign w_last = (r_count == c_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_active    <= RESET_TABLE;
            r_shadow    <= '0;
            r_count     <= '0;
            r_f         <= 1'b0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done      <= 1'b0;
            r_out_valid <= bus.in_valid;
            // Reads the table as it stood before this edge, so an evaluation
            // coinciding with a commit still sees the old function.
            if (bus.in_valid) begin
                r_f <= r_active[bus.in_vec];
            end
            if (bus.cfg_restart) begin
                r_count <= '0;
                r_busy  <= 1'b0;
            end else if (bus.cfg_en) begin
                r_shadow <= w_merged;
                r_count  <= r_count + 1'b1;
                r_busy   <= !w_last;
                if (w_last) begin
                    r_active <= w_merged;
                    r_done   <= 1'b1;
                end
            end
        end
    end

    assign bus.f         = r_f;
    assign bus.out_valid = r_out_valid;
    assign bus.cfg_busy  = r_busy;
    assign bus.cfg_done  = r_done;
endmodule
`default_nettype wire
